// File: rtl/master_reader.sv
// master_reader
//   Initiator for the packet slave. Issues one read burst per accepted start,
//   captures the returned bytes after a fixed read latency, splits them into a
//   16-bit header (addr 0 = MSB, addr 1 = LSB) and a payload byte stream, and
//   checks that consecutive headers increment by one.
//
// Build option:
//   MASTER_READER_CHKSUM_EN  when defined, chksum is the mod-256 sum of the
//                            packet payload; otherwise chksum is tied to 0.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start, pkt_len    packet request (sampled in IDLE) and total address count
//   ram_rd_rq,
//   rd_addr, new_msg  read burst towards the slave
//   data_i            byte returned RD_LAT cycles after its address
//   hdr, hdr_valid    last captured header and its update strobe
//   pay_data,
//   pay_valid,
//   pay_last          payload byte stream, last flag on the final byte
//   busy, done        packet in progress / end-of-packet strobe
//   seq_err           header was not previous+1 (with done)
//   pkt_cnt, err_cnt  completed packets (wraps), sequence errors (saturates)
//   chksum            payload checksum
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start, rd_addr parked at 0
// REQ    | one address per cycle, 0 .. L-1, ram_rd_rq high
// DRAIN  | burst issued, waiting for the last byte to be captured
// DONE   | single cycle: done strobe, sequence check, counters update
module master_reader #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] pkt_len,
  output logic              ram_rd_rq,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              new_msg,
  input  logic [DATA_W-1:0] data_i,
  output logic [15:0]       hdr,
  output logic              hdr_valid,
  output logic [DATA_W-1:0] pay_data,
  output logic              pay_valid,
  output logic              pay_last,
  output logic              busy,
  output logic              done,
  output logic              seq_err,
  output logic [15:0]       pkt_cnt,
  output logic [7:0]        err_cnt,
  output logic [DATA_W-1:0] chksum
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN, S_DONE} state_t;
  typedef enum logic [1:0] {C_HMSB, C_HLSB, C_PAY, C_LAST} cls_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] len_r;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-1:0] last_addr;
  logic [ADDR_W-1:0] len_nxt;

  logic              tag_in_v;
  cls_t              tag_in_c;
  logic              tag_v [RD_LAT];
  cls_t              tag_c [RD_LAT];
  logic              cap_v;
  cls_t              cap_c;

  logic [7:0]        hdr_msb;
  logic [15:0]       prev_hdr;
  logic              base_valid;

  assign last_addr = len_r - ADDR_W'(1);
  // Lengths below 3 (including 0) still fetch the header plus one payload byte.
  assign len_nxt   = (pkt_len < ADDR_W'(3)) ? ADDR_W'(3) : pkt_len;
  assign rd_addr   = addr_r;
  assign cap_v     = tag_v[RD_LAT-1];
  assign cap_c     = tag_c[RD_LAT-1];
  assign seq_err   = done && base_valid && (hdr != prev_hdr + 16'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ram_rd_rq = 1'b0;
    new_msg   = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    tag_in_v  = 1'b0;
    tag_in_c  = C_PAY;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = S_REQ;
      end
      S_REQ: begin
        ram_rd_rq = 1'b1;
        new_msg   = (addr_r == '0);
        tag_in_v  = 1'b1;
        if (addr_r == '0)                 tag_in_c = C_HMSB;
        else if (addr_r == ADDR_W'(1))    tag_in_c = C_HLSB;
        else if (addr_r == last_addr)     tag_in_c = C_LAST;
        else                              tag_in_c = C_PAY;
        if (addr_r == last_addr) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        // pay_last is registered, so it rises the cycle after the last capture;
        // moving on then places done exactly one cycle after pay_last.
        if (pay_last) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_r  <= ADDR_W'(3);
      addr_r <= '0;
    end else begin
      if (state == S_IDLE && start) len_r <= len_nxt;
      if (state == S_REQ && addr_r != last_addr) addr_r <= addr_r + ADDR_W'(1);
      else if (state == S_DONE)                  addr_r <= '0;
    end
  end

  // Tag pipeline: stage RD_LAT-1 lines up with the byte on data_i.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        tag_v[i] <= 1'b0;
        tag_c[i] <= C_PAY;
      end
    end else begin
      tag_v[0] <= tag_in_v;
      tag_c[0] <= tag_in_c;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_c[i] <= tag_c[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hdr_msb   <= '0;
      hdr       <= '0;
      hdr_valid <= 1'b0;
      pay_data  <= '0;
      pay_valid <= 1'b0;
      pay_last  <= 1'b0;
    end else begin
      hdr_valid <= 1'b0;
      pay_valid <= 1'b0;
      pay_last  <= 1'b0;
      if (cap_v) begin
        case (cap_c)
          C_HMSB: hdr_msb <= data_i[7:0];
          C_HLSB: begin
            hdr       <= {hdr_msb, data_i[7:0]};
            hdr_valid <= 1'b1;
          end
          C_PAY, C_LAST: begin
            pay_data  <= data_i;
            pay_valid <= 1'b1;
            pay_last  <= (cap_c == C_LAST);
          end
        endcase
      end
    end
  end

  // The first packet after reset only establishes the baseline header.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_hdr   <= '0;
      base_valid <= 1'b0;
      pkt_cnt    <= '0;
      err_cnt    <= '0;
    end else if (state == S_DONE) begin
      prev_hdr   <= hdr;
      base_valid <= 1'b1;
      pkt_cnt    <= pkt_cnt + 16'd1;
      if (seq_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

`ifdef MASTER_READER_CHKSUM_EN
  logic [DATA_W-1:0] chk_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_r <= '0;
    end else if (state == S_IDLE && start) begin
      chk_r <= '0;
    end else if (cap_v && (cap_c == C_PAY || cap_c == C_LAST)) begin
      chk_r <= chk_r + data_i;
    end
  end

  assign chksum = chk_r;
`else
  assign chksum = '0;
`endif

endmodule

// File: tb/tb_master_reader.sv
// Testbench for master_reader: slave model on data_i, timeline-based reference
// model checked every cycle, plus directed scenarios with literal expectations.
module tb_master_reader;
  localparam int RD_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] pkt_len;
  logic        ram_rd_rq;
  logic [15:0] rd_addr;
  logic        new_msg;
  logic [7:0]  data_i;
  logic [15:0] hdr;
  logic        hdr_valid;
  logic [7:0]  pay_data;
  logic        pay_valid;
  logic        pay_last;
  logic        busy;
  logic        done;
  logic        seq_err;
  logic [15:0] pkt_cnt;
  logic [7:0]  err_cnt;
  logic [7:0]  chksum;

  master_reader #(.ADDR_W(16), .DATA_W(8), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .pkt_len(pkt_len),
    .ram_rd_rq(ram_rd_rq), .rd_addr(rd_addr), .new_msg(new_msg),
    .data_i(data_i), .hdr(hdr), .hdr_valid(hdr_valid),
    .pay_data(pay_data), .pay_valid(pay_valid), .pay_last(pay_last),
    .busy(busy), .done(done), .seq_err(seq_err),
    .pkt_cnt(pkt_cnt), .err_cnt(err_cnt), .chksum(chksum)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      n_pass++;
    end
  endtask

  // Reference model: packet timeline relative to its first REQ cycle m_c0.
  logic [7:0]  pkt_bytes [64];
  logic [7:0]  pre_bytes [8];
  int          m_c0;
  int          m_L;
  logic [15:0] m_pkt_hdr, m_hdr, m_prev, m_pkt_cnt;
  logic        m_base, m_exp_err;
  logic [7:0]  m_err_cnt, m_sum;

  task automatic model_reset();
    m_c0 = -1000000; m_L = 3;
    m_pkt_hdr = 0; m_hdr = 0; m_prev = 0; m_pkt_cnt = 0;
    m_base = 0; m_exp_err = 0; m_err_cnt = 0; m_sum = 0;
  endtask

  // Slave: byte for the address seen in cycle t is on data_i during t+RD_LAT.
  logic [15:0] sh_a [8];
  logic        sh_r [8];
  always @(negedge clk) begin
    for (int i = 7; i > 0; i--) begin
      sh_a[i] = sh_a[i-1];
      sh_r[i] = sh_r[i-1];
    end
    sh_a[0] = rd_addr;
    sh_r[0] = ram_rd_rq;
    data_i = sh_r[RD_LAT] ? pkt_bytes[sh_a[RD_LAT][5:0]] : 8'($urandom);
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin : cmp
    int off, doff, ea, pidx;
    off  = cyc - m_c0;
    doff = m_L + RD_LAT + 1;
    pidx = off - RD_LAT - 1;
    if (off == RD_LAT + 2) m_hdr = m_pkt_hdr;
    ea = (off >= 0 && off < m_L) ? off : ((off >= m_L && off <= doff) ? m_L - 1 : 0);
    chk("ram_rd_rq", 32'(ram_rd_rq), 32'(off >= 0 && off < m_L));
    chk("new_msg",   32'(new_msg),   32'(off == 0));
    chk("rd_addr",   32'(rd_addr),   32'(ea));
    chk("hdr_valid", 32'(hdr_valid), 32'(off == RD_LAT + 2));
    chk("hdr",       32'(hdr),       32'(m_hdr));
    chk("pay_valid", 32'(pay_valid), 32'(pidx >= 2 && pidx <= m_L - 1));
    if (pidx >= 2 && pidx <= m_L - 1) chk("pay_data", 32'(pay_data), 32'(pkt_bytes[pidx]));
    chk("pay_last",  32'(pay_last),  32'(off == m_L + RD_LAT));
    chk("done",      32'(done),      32'(off == doff));
    chk("busy",      32'(busy),      32'(off >= 0 && off <= doff));
    chk("seq_err",   32'(seq_err),   32'(off == doff && m_exp_err));
    chk("pkt_cnt",   32'(pkt_cnt),   32'(m_pkt_cnt));
    chk("err_cnt",   32'(err_cnt),   32'(m_err_cnt));
`ifdef MASTER_READER_CHKSUM_EN
    if (off == doff) chk("chksum", 32'(chksum), 32'(m_sum));
`else
    chk("chksum", 32'(chksum), 32'd0);
`endif
    if (off == doff) begin
      m_pkt_cnt = m_pkt_cnt + 16'd1;
      if (m_exp_err && m_err_cnt != 8'hFF) m_err_cnt = m_err_cnt + 8'd1;
    end
  end

  // Monitor for the directed literal expectations.
  logic [7:0] mon_q [$];
  int         mon_err, mon_done, mon_rq_cycles, mon_new, mon_bursts, mon_last_cnt;
  logic [7:0] mon_last_data, mon_chk;
  logic       mon_prev_rq = 1'b0;

  always @(negedge clk) begin
    if (pay_valid) mon_q.push_back(pay_data);
    if (pay_last) begin mon_last_data = pay_data; mon_last_cnt++; end
    if (seq_err) mon_err++;
    if (done) begin mon_done++; mon_chk = chksum; end
    if (ram_rd_rq) mon_rq_cycles++;
    if (new_msg) mon_new++;
    if (ram_rd_rq && !mon_prev_rq) mon_bursts++;
    mon_prev_rq = ram_rd_rq;
  end

  task automatic mon_clear();
    mon_q.delete();
    mon_err = 0; mon_done = 0; mon_rq_cycles = 0; mon_new = 0;
    mon_bursts = 0; mon_last_cnt = 0; mon_last_data = 0; mon_chk = 0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_idle();
    wait_until(m_c0 + m_L + RD_LAT + 2);
  endtask

  // Called at posedge+2 of an idle cycle; the start is accepted at the next edge.
  task automatic issue(input logic [15:0] h, input int plen, input bit use_pre);
    int lm;
    lm = (plen < 3) ? 3 : plen;
    pkt_bytes[0] = h[15:8];
    pkt_bytes[1] = h[7:0];
    m_sum = 0;
    for (int a = 2; a < lm; a++) begin
      pkt_bytes[a] = use_pre ? pre_bytes[a-2] : 8'($urandom);
      m_sum = m_sum + pkt_bytes[a];
    end
    m_exp_err = m_base && (h != m_prev + 16'd1);
    m_prev    = h;
    m_base    = 1'b1;
    m_pkt_hdr = h;
    m_L       = lm;
    m_c0      = cyc + 1;
    start     = 1'b1;
    pkt_len   = 16'(plen);
    @(posedge clk);
    #2;
    start   = 1'b0;
    pkt_len = 16'($urandom);
  endtask

  task automatic send(input logic [15:0] h, input int plen, input bit use_pre);
    wait_idle();
    issue(h, plen, use_pre);
    wait_idle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) begin @(posedge clk); #2; end
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #2; end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin sh_a[i] = 0; sh_r[i] = 0; end
    for (int i = 0; i < 64; i++) pkt_bytes[i] = 0;
    rst = 1'b1; start = 1'b0; pkt_len = 0; data_i = 0;
    model_reset();
    mon_clear();
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk); #2;

    chk("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
    chk("rst_busy",    32'(busy),    32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);

    // Reset in the middle of an L=8 burst.
    mon_clear();
    issue(16'h0100, 8, 1'b0);
    repeat (4) begin @(posedge clk); #2; end
    chk("abort_at_addr", 32'(rd_addr), 32'd4);
    rst = 1'b1;
    model_reset();
    #1;
    chk("abort_rq",   32'(ram_rd_rq), 32'd0);
    chk("abort_busy", 32'(busy),      32'd0);
    repeat (2) begin @(posedge clk); #2; end
    rst = 1'b0;
    repeat (6) begin @(posedge clk); #2; end
    chk("abort_done",    32'(mon_done), 32'd0);
    chk("abort_pkt_cnt", 32'(pkt_cnt),  32'd0);

    // Single packet, header 0x1234, payload A0..A3.
    mon_clear();
    pre_bytes[0] = 8'hA0; pre_bytes[1] = 8'hA1; pre_bytes[2] = 8'hA2; pre_bytes[3] = 8'hA3;
    send(16'h1234, 6, 1'b1);
    chk("single_rq_cycles", 32'(mon_rq_cycles), 32'd6);
    chk("single_new_msg",   32'(mon_new),       32'd1);
    chk("single_pay_n",     32'(mon_q.size()),  32'd4);
    if (mon_q.size() == 4) begin
      chk("single_pay0", 32'(mon_q[0]), 32'hA0);
      chk("single_pay1", 32'(mon_q[1]), 32'hA1);
      chk("single_pay2", 32'(mon_q[2]), 32'hA2);
      chk("single_pay3", 32'(mon_q[3]), 32'hA3);
    end
    chk("single_last",    32'(mon_last_data), 32'hA3);
    chk("single_hdr",     32'(hdr),           32'h1234);
    chk("single_pkt_cnt", 32'(pkt_cnt),       32'd1);
    chk("single_seq_err", 32'(mon_err),       32'd0);
    chk("single_done",    32'(mon_done),      32'd1);

    // Sequence check from a fresh baseline.
    do_reset();
    mon_clear();
    send(16'h0005, 4, 1'b0);
    send(16'h0006, 7, 1'b0);
    chk("seq_no_err_yet", 32'(mon_err), 32'd0);
    send(16'h0009, 5, 1'b0);
    chk("seq_err_third", 32'(mon_err), 32'd1);
    chk("seq_err_cnt",   32'(err_cnt), 32'd1);
    send(16'h000A, 3, 1'b0);
    chk("seq_resync", 32'(mon_err), 32'd1);

    // Header wrap 0xFFFF -> 0x0000 (0xFFFF itself follows 0x000A: an error).
    send(16'hFFFF, 4, 1'b0);
    chk("wrap_ffff_err_cnt", 32'(err_cnt), 32'd2);
    mon_clear();
    send(16'h0000, 4, 1'b0);
    chk("wrap_no_err",  32'(mon_err), 32'd0);
    chk("wrap_pkt_cnt", 32'(pkt_cnt), 32'd6);

    // Minimum lengths.
    mon_clear();
    send(m_prev + 16'd1, 1, 1'b0);
    chk("len1_rq_cycles", 32'(mon_rq_cycles), 32'd3);
    chk("len1_pay_n",     32'(mon_q.size()),  32'd1);
    chk("len1_last_n",    32'(mon_last_cnt),  32'd1);
    mon_clear();
    send(m_prev + 16'd1, 0, 1'b0);
    chk("len0_rq_cycles", 32'(mon_rq_cycles), 32'd3);

    // start while busy is ignored.
    mon_clear();
    wait_idle();
    issue(m_prev + 16'd1, 6, 1'b0);
    repeat (2) begin @(posedge clk); #2; end
    start = 1'b1; pkt_len = 16'd9;
    @(posedge clk); #2;
    start = 1'b0;
    wait_idle();
    repeat (3) begin @(posedge clk); #2; end
    chk("busy_start_bursts", 32'(mon_bursts), 32'd1);

    // start during the DONE cycle is ignored.
    mon_clear();
    issue(m_prev + 16'd1, 4, 1'b0);
    wait_until(m_c0 + m_L + RD_LAT + 1);
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #2; end
    chk("done_start_bursts", 32'(mon_bursts), 32'd1);

    // Checksum of 0x80, 0x90, 0x10.
    mon_clear();
    pre_bytes[0] = 8'h80; pre_bytes[1] = 8'h90; pre_bytes[2] = 8'h10;
    send(m_prev + 16'd1, 5, 1'b1);
`ifdef MASTER_READER_CHKSUM_EN
    chk("chksum_lit", 32'(mon_chk), 32'h20);
`else
    chk("chksum_off", 32'(mon_chk), 32'h00);
`endif

    // Randomized packets.
    for (int n = 0; n < 60; n++) begin
      logic [15:0] h;
      int plen, gap, k;
      h    = ($urandom_range(0, 3) == 0) ? 16'($urandom) : m_prev + 16'd1;
      plen = $urandom_range(0, 12);
      gap  = $urandom_range(0, 3);
      wait_idle();
      repeat (gap) begin @(posedge clk); #2; end
      issue(h, plen, 1'b0);
      if ($urandom_range(0, 2) == 0) begin
        k = $urandom_range(0, m_L);
        repeat (k) begin @(posedge clk); #2; end
        start = 1'b1; pkt_len = 16'($urandom);
        @(posedge clk); #2;
        start = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) begin
        wait_until(m_c0 + m_L + RD_LAT + 1);
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
      end
    end
    wait_idle();
    repeat (4) begin @(posedge clk); #2; end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/master_reader.md
Name: master_reader

Overview:
- Initiator-side counterpart of the packet slave. Drives ram_rd_rq/rd_addr bursts and issues the new_msg strobe.
- Captures the returned byte stream on data_i. Splits it into the 16-bit header (addr 0 = MSB, addr 1 = LSB) and the payload (addr 2..L-1).
- Checks that headers increment by one between packets, and exposes the payload as a byte stream plus status counters.

Parameters:
- ADDR_W, 16, width of rd_addr and pkt_len.
- DATA_W, 8, width of data_i and pay_data.
- RD_LAT, 2, cycles from rd_addr presentation to the matching byte on data_i (range 1..7).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  request one packet read; sampled only in IDLE.
- pkt_len  in  ADDR_W  total addresses per packet including the 2 header bytes; latched on accepted start.
- ram_rd_rq  out  1  read request to slave, high for the whole address burst.
- rd_addr  out  ADDR_W  read address to slave.
- new_msg  out  1  one-cycle strobe coincident with rd_addr=0.
- data_i  in  DATA_W  byte returned by slave.
- hdr  out  16  last captured header.
- hdr_valid  out  1  one-cycle strobe when hdr updates.
- pay_data  out  DATA_W  payload byte.
- pay_valid  out  1  payload byte strobe (no backpressure).
- pay_last  out  1  marks the final payload byte; asserted with pay_valid.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle end-of-packet strobe.
- seq_err  out  1  one-cycle strobe with done when the header is not previous+1.
- pkt_cnt  out  16  completed packets, wraps.
- err_cnt  out  8  sequence errors, saturates at 255.
- chksum  out  DATA_W  payload checksum (see Optional Feature).

Behaviour:
- Reset values: every output 0 (rd_addr=0, hdr=0, counters 0); FSM in IDLE; baseline-valid flag cleared. Assertion of rst mid-packet aborts immediately; no done is issued.
- FSM states and transitions:
  - IDLE: start=1 latches L=max(pkt_len,3) and moves to REQ.
  - REQ: one address per cycle. The first REQ cycle drives rd_addr=0, ram_rd_rq=1 and new_msg=1. Address increments each cycle up to L-1. After addr L-1 has been driven, go to DRAIN.
  - DRAIN: wait until the last tagged byte is captured, then go to DONE.
  - DONE: one cycle; done=1, then back to IDLE.
- start outside IDLE is ignored. start=1 during the DONE cycle is also ignored.
- Burst shape: ram_rd_rq is high for exactly L consecutive cycles, then low. rd_addr holds L-1 after the burst and returns to 0 in IDLE.
- Capture: a tag pipeline of depth RD_LAT carries {valid, index class: hdr_msb, hdr_lsb, payload, last}. The byte for the address driven in cycle t is sampled from data_i at edge t+RD_LAT.
- Outputs are registered and appear in cycle t+RD_LAT+1:
  - Payload bytes: pay_valid=1, pay_data=sampled byte. pay_last=1 for addr L-1 only.
  - hdr_lsb: hdr={msb,lsb} and hdr_valid=1.
- done is asserted the cycle after pay_last.
- Sequence check, evaluated in the DONE cycle:
  - First packet after reset only sets the baseline; seq_err=0.
  - On later packets, seq_err=1 if hdr != prev_hdr+1 (mod 2^16). On error, err_cnt increments, saturating at 255.
  - prev_hdr<=hdr on every packet; resync happens on error.
- pkt_cnt increments by one on every done, wrapping FFFF->0000.
- L wraps are not supported: pkt_len=0 is treated as L=3.

Optional Feature:
- Macro MASTER_READER_CHKSUM_EN.
- Defined: chksum is an 8-bit modulo-256 sum of the packet's payload bytes. It is cleared at the accepted start and becomes valid/stable in the DONE cycle, holding until the next start.
- Undefined: no accumulator is built and chksum is tied to 0.

Test Plan:
- Reset mid-burst: assert rst at rd_addr=4 of an L=8 packet -> ram_rd_rq, busy and all outputs 0 next edge; done never pulses; pkt_cnt=0.
- Single packet: L=6, RD_LAT=2, slave model returns hdr 0x1234 and payload 0xA0..0xA3 -> ram_rd_rq high 6 cycles; new_msg with rd_addr=0; hdr_valid with hdr=0x1234; four pay_valid with 0xA0,0xA1,0xA2,0xA3; pay_last on 0xA3; done next cycle; seq_err=0; pkt_cnt=1.
- Sequence check: three packets with headers 0x0005, 0x0006, 0x0009 -> seq_err only on the third; err_cnt=1. A fourth packet with 0x000A gives no error.
- Header wrap: headers 0xFFFF then 0x0000 -> no seq_err.
- Minimum length and start rules: pkt_len=1 gives 3 addresses (0,1,2) and one payload byte with pay_last. start pulsed while busy is ignored (exactly one burst).
- Checksum with MASTER_READER_CHKSUM_EN defined: payload 0x80,0x90,0x10 gives chksum=0x20 at done. Without the macro, chksum=0 throughout.
